// File: rtl/rv32_rf_multiport.sv
// rv32_rf_multiport: parametrised RV32 integer register file with post-reset clear sweep,
// optional same-cycle write bypass and a sticky out-of-range write flag.
module rv32_rf_multiport #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int NRD        = 2,
    parameter int WR_BYPASS  = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [4:0]          rd_addr_i,
    input  logic [XLEN-1:0]     rd_dati_i,
    input  logic [NRD*5-1:0]    rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_dato_o,
    output logic                ready_o,
    output logic                addr_err_o
);
    localparam int CW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);
    localparam logic [CW-1:0] LAST = CW'(NREGS - 1);
    typedef enum logic [1:0] {S_CLR, S_PEND, S_RUN} state_t;
    state_t          state_q;
    logic [CW-1:0]   clr_cnt_q;
    logic            ready_q;
    logic            addr_err_q;
    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_ok;
    // full 5-bit compare so out-of-range addresses never alias onto low registers
    assign wr_ok = we_i && rd_addr_i != '0 && {1'b0, rd_addr_i} < NR;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLR_ON_RST != 0) ? S_CLR : S_PEND;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_PEND: begin
                    state_q <= S_RUN;
                    ready_q <= 1'b1;
                end
                default: if (we_i && {1'b0, rd_addr_i} >= NR) addr_err_q <= 1'b1;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLR) mem_q[clr_cnt_q] <= '0;
            else if (state_q == S_RUN && wr_ok) mem_q[rd_addr_i[CW-1:0]] <= rd_dati_i;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [4:0] a;
        assign a = rs_addr_i[k*5 +: 5];
        assign rs_dato_o[k*XLEN +: XLEN] = (!ready_q || a == '0 || {1'b0, a} >= NR) ? '0 :
                                           (WR_BYPASS != 0 && we_i && rd_addr_i == a) ? rd_dati_i :
                                           mem_q[a[CW-1:0]];
    end
    assign ready_o    = ready_q;
    assign addr_err_o = addr_err_q;
endmodule

// File: tb/tb_rv32_rf_multiport.sv
// tb_rv32_rf_multiport: vector table plus scoreboard for a 32-reg bypassing RF,
// hand sequences for a 16-reg non-bypassing RF and reset-during-sweep.
module tb_rv32_rf_multiport;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        we0 = 1'b0;
    logic [4:0]  wa0 = '0;
    logic [31:0] wd0 = '0;
    logic [14:0] rs0 = '0;
    logic [95:0] rd0;
    logic        rdy0, err0;

    logic        we1 = 1'b0;
    logic [4:0]  wa1 = '0;
    logic [31:0] wd1 = '0;
    logic [9:0]  rs1 = '0;
    logic [63:0] rd1;
    logic        rdy1, err1;

    rv32_rf_multiport #(.NRD(3)) u0 (
        .clk(clk), .rst(rst), .we_i(we0), .rd_addr_i(wa0), .rd_dati_i(wd0),
        .rs_addr_i(rs0), .rs_dato_o(rd0), .ready_o(rdy0), .addr_err_o(err0)
    );
    rv32_rf_multiport #(.NREGS(16), .NRD(2), .WR_BYPASS(0), .CLR_ON_RST(0)) u1 (
        .clk(clk), .rst(rst), .we_i(we1), .rd_addr_i(wa1), .rd_dati_i(wd1),
        .rs_addr_i(rs1), .rs_dato_o(rd1), .ready_o(rdy1), .addr_err_o(err1)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic            we;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [2:0][4:0] ra;
        logic [2:0][31:0] ex;
        logic            err;
    } vec_t;

    typedef struct packed {
        logic [2:0][31:0] ex;
        logic             err;
    } exp_t;

    exp_t sbq[$];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
        v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2;
        v.err = 1'b0;
        return v;
    endfunction

    // counts edges until u0 is ready; also records when u1 became ready
    task automatic wait_rdy(input string nm, input int exp, output int r1);
        int cyc;
        cyc = 0;
        r1 = -1;
        while (!rdy0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rdy1 && r1 < 0) r1 = cyc;
        end
        chk(nm, cyc, exp);
    endtask

    task automatic step1(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        we1 = we; wa1 = wa; wd1 = wd; rs1 = {r1, r0};
        #2;
    endtask

    initial begin
        vec_t tbl[10];
        exp_t e;
        int   r1;
        tbl[0] = mk(1, 5,  32'hDEADBEEF, 5, 0, 6,   32'hDEADBEEF, 0, 0);
        tbl[1] = mk(0, 0,  0,            5, 5, 5,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2] = mk(1, 0,  32'h1234,     0, 5, 0,   0, 32'hDEADBEEF, 0);
        tbl[3] = mk(0, 0,  0,            0, 0, 0,   0, 0, 0);
        tbl[4] = mk(1, 3,  32'd11,       3, 7, 1,   32'd11, 0, 0);
        tbl[5] = mk(1, 7,  32'd22,       3, 7, 3,   32'd11, 32'd22, 32'd11);
        tbl[6] = mk(0, 0,  0,            3, 7, 3,   32'd11, 32'd22, 32'd11);
        tbl[7] = mk(1, 31, 32'hFFFFFFFF, 31, 30, 31, 32'hFFFFFFFF, 0, 32'hFFFFFFFF);
        tbl[8] = mk(1, 3,  32'd33,       3, 31, 2,  32'd33, 32'hFFFFFFFF, 0);
        tbl[9] = mk(0, 0,  0,            3, 1, 31,  32'd33, 0, 32'hFFFFFFFF);

        rs0 = {5'd3, 5'd2, 5'd1};
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_u0", 32'(rdy0), 0);
        chk("rst_err_u0", 32'(err0), 0);
        chk("rst_ready_u1", 32'(rdy1), 0);
        chk("rst_err_u1", 32'(err1), 0);
        chk("rst_read_u0", rd0[31:0] | rd0[63:32] | rd0[95:64], 0);
        rst = 1'b0;
        wait_rdy("T1_ready_rise", 32, r1);
        chk("pend_ready_rise", r1, 1);
        for (int i = 1; i < 32; i++) begin
            rs0 = {5'(i), 5'(i), 5'(i)};
            #1;
            chk($sformatf("T1_zero_x%0d", i), rd0[31:0] | rd0[63:32] | rd0[95:64], 0);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            we0 = tbl[i].we; wa0 = tbl[i].wa; wd0 = tbl[i].wd; rs0 = tbl[i].ra;
            sbq.push_back('{ex: tbl[i].ex, err: tbl[i].err});
            #2;
            e = sbq.pop_front();
            for (int k = 0; k < 3; k++)
                chk($sformatf("vec%0d_p%0d", i, k), rd0[k*32 +: 32], e.ex[k]);
            chk($sformatf("vec%0d_err", i), 32'(err0), 32'(e.err));
        end
        @(negedge clk);
        we0 = 1'b0;

        step1(1, 5, 32'd1, 0, 0);
        step1(1, 5, 32'hDEADBEEF, 5, 5);
        chk("T2_nobyp_same", rd1[31:0], 32'd1);
        step1(0, 0, 0, 5, 0);
        chk("T2_nobyp_next", rd1[31:0], 32'hDEADBEEF);
        step1(1, 16, 32'hA5A5A5A5, 0, 16);
        chk("T4_x0", rd1[31:0], 0);
        chk("T4_x16_same", rd1[63:32], 0);
        chk("T4_err_pre", 32'(err1), 0);
        step1(0, 0, 0, 0, 16);
        chk("T4_err_set", 32'(err1), 1);
        chk("T4_x0_after", rd1[31:0], 0);
        chk("T4_x16_after", rd1[63:32], 0);
        step1(1, 15, 32'd7, 0, 16);
        step1(1, 0, 32'h1234, 15, 0);
        chk("T4_x15", rd1[31:0], 32'd7);
        chk("T3_x0_u1", rd1[63:32], 0);
        chk("T4_err_sticky", 32'(err1), 1);
        step1(1, 31, 32'd9, 31, 15);
        chk("alias_rd31", rd1[31:0], 0);
        step1(0, 0, 0, 15, 0);
        chk("alias_wr31", rd1[31:0], 32'd7);
        chk("T4_err_sticky2", 32'(err1), 1);
        @(negedge clk);
        we1 = 1'b0;

        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd99; rs0 = {5'd0, 5'd0, 5'd9};
        #2;
        chk("T6_x9_byp", rd0[31:0], 32'd99);
        @(negedge clk);
        we0 = 1'b0;
        #2;
        chk("T6_x9_stored", rd0[31:0], 32'd99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("T6_mid_sweep_ready", 32'(rdy0), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'd77;
        wait_rdy("T6_ready_rise", 32, r1);
        we0 = 1'b0;
        chk("T6_err_u1_cleared", 32'(err1), 0);
        rs0 = {5'd5, 5'd2, 5'd9};
        #1;
        chk("T6_x9_zero", rd0[31:0], 0);
        chk("T6_x2_we_ignored", rd0[63:32], 0);
        chk("T6_x5_zero", rd0[95:64], 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
